uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx byte channel (tx_data / tx_data_valid / tx_data_ready) between NUM_REQ byte-stream requesters.
- Round-robin arbitration at packet granularity: a grant is held until the requester's byte flagged last is accepted, so messages never interleave on the serial line.
- Sits between producers (banner sender, rx echo path, debug/status streams) and the uart_tx instance in the UART top level.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYC, 27000, stall cycles before a locked grant is revoked (1 ms at 27 MHz; used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  reset: one clock; reset is asynchronous and active-high
- req_data  in  NUM_REQ*8  byte per requester; requester i uses bits [i*8 +: 8]
- req_valid  in  NUM_REQ  per-requester byte valid
- req_last  in  NUM_REQ  marks the final byte of a packet; sampled with req_valid
- req_ready  out  NUM_REQ  per-requester accept
- tx_data  out  8  byte to uart_tx
- tx_data_valid  out  1  byte valid to uart_tx
- tx_data_ready  in  1  uart_tx accept
- grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester
- busy  out  1  high while a grant is locked
- timeout_pulse  out  1  one-cycle pulse when a grant is revoked (tied 0 without the optional feature)

Behaviour:
- States: IDLE, LOCK. Registers: state, grant_id, rr_ptr, plus the timeout counter when enabled.
- Reset values (async, rst=1):
  - state=IDLE, grant_id=0, rr_ptr=0, busy=0, timeout_pulse=0.
  - req_ready=0, tx_data_valid=0, tx_data=0.
- IDLE:
  - tx_data_valid=0, req_ready=0.
  - If any req_valid is set, grant goes to the first requester with valid set, searching from rr_ptr upward modulo NUM_REQ.
  - Registers grant_id and moves to LOCK; busy=1 from the next cycle.
  - If no req_valid is set, stays in IDLE.
- LOCK (combinational datapath, registered grant):
  - tx_data = req_data[g], tx_data_valid = req_valid[g], req_ready[g] = tx_data_ready.
  - All other req_ready = 0. tx_data=0 whenever tx_data_valid=0.
- Handshake:
  - A byte transfers when tx_data_valid and tx_data_ready are both high.
  - Requesters must hold req_data and req_last stable while req_valid is high and not accepted.
- Release: a transfer with req_last[g]=1 leads to state=IDLE, rr_ptr=(g+1) mod NUM_REQ, busy=0 on the next cycle.
- Latency:
  - The first byte is presented to uart_tx one cycle after the IDLE cycle in which the request is seen.
  - Exactly one IDLE cycle separates consecutive packets.
- Boundary conditions:
  - Requester valid rising in the same cycle as a release: considered in the following IDLE cycle, under normal round-robin order.
  - Granted requester deasserts req_valid mid-packet: the grant is held and the channel stays idle (tx_data_valid=0). Non-granted requesters stall.
  - Single-byte packet (req_last on the first byte): locks and releases after one transfer.
  - rr_ptr wrap-around: from NUM_REQ-1 it wraps to 0.
  - Reset mid-packet: immediate return to IDLE with all outputs at reset values. The partial packet is discarded; the requester must restart it.
  - tx_data_ready held low forever: the grant is held indefinitely unless the optional feature is enabled.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- With the macro defined:
  - A 32-bit counter clears on every transfer and on entry to LOCK.
  - It increments each LOCK cycle in which req_valid[g]=0.
  - When it reaches TIMEOUT_CYC: forced release (state=IDLE, rr_ptr=g+1) and timeout_pulse=1 for one cycle.
  - Cycles where valid=1 and ready=0 (uart_tx busy) do not count.
- Without the macro: no counter, timeout_pulse tied 0, and the grant is released only on a last byte.

Decomposition:
- Package uart_arb_pkg holds:
  - the state typedef (enum IDLE, LOCK);
  - a function for the grant-index width, $clog2 with a minimum of 1;
  - the default TIMEOUT_CYC constant.
- Sub-module rr_picker (combinational): inputs are the request vector and rr_ptr; outputs are a found flag and an index. It is reusable for other shared resources.

Test Plan:
- Reset release, no requests -> tx_data_valid=0, busy=0, grant_id=0; stays in IDLE for 100 cycles.
- Req0 sends the 3-byte packet 0x48,0x49,0x0A (last on 0x0A) with ready pulsing every 4 cycles -> exactly 3 transfers in order, busy drops the cycle after 0x0A, rr_ptr=1.
- Req0 and req2 both valid in the same IDLE cycle with rr_ptr=0 -> req0's packet completes fully, then one IDLE cycle, then grant_id=2. No interleaved bytes.
- With rr_ptr=3 (NUM_REQ=4), req1 and req3 valid -> grant to 3 first, then wrap to 1.
- rst asserted while on byte 2 of a 5-byte packet -> all outputs 0 within the same cycle. After release, a fresh request from req1 is granted normally.
- With UART_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=16: granted requester drops valid after byte 1 -> timeout_pulse at stall cycle 16, then a waiting req2 is granted. Without the macro, the grant is held and timeout_pulse stays 0.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart_tx byte-channel arbiter.
//
// Contents:
//   arb_state_t          IDLE / LOCK arbiter states
//   grant_width()        grant index width, $clog2(n) with a floor of 1
//   DEFAULT_TIMEOUT_CYC  default stall limit (1 ms at 27 MHz)
package uart_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int unsigned DEFAULT_TIMEOUT_CYC = 27000;

    // A single requester would give $clog2 = 0; keep the index at least 1 bit.
    function automatic int unsigned grant_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first set request at or above
// ptr, wrapping to the lowest set request below ptr. Reusable for any shared
// resource.
//
// Ports:
//   req    in  N  request vector
//   ptr    in  W  search start index (must be < N)
//   found  out 1  at least one request is set
//   idx    out W  selected request index (0 when nothing is found)
module rr_picker #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic         hi_found;
    logic [W-1:0] hi_idx;
    logic         lo_found;
    logic [W-1:0] lo_idx;

    // Descending loops so the lowest qualifying index is the one left standing.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo_found = 1'b1;
                lo_idx   = W'(j);
                if (j >= int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = W'(j);
                end
            end
        end
    end

    assign found = hi_found | lo_found;
    assign idx   = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx byte channel between
// NUM_REQ byte-stream requesters. A grant is held until the granted requester's
// last byte is accepted, so packets never interleave on the serial line.
//
// Optional build macro: UART_ARB_TIMEOUT_EN adds a stall counter that revokes a
// grant after TIMEOUT_CYC cycles with the granted requester's valid low.
//
// Ports:
//   clk            in   1          system clock
//   rst            in   1          asynchronous active-high reset
//   req_data       in   NUM_REQ*8  byte per requester, requester i at [i*8 +: 8]
//   req_valid      in   NUM_REQ    per-requester byte valid
//   req_last       in   NUM_REQ    final byte of a packet, sampled with req_valid
//   req_ready      out  NUM_REQ    per-requester accept
//   tx_data        out  8          byte to uart_tx (0 when tx_data_valid is low)
//   tx_data_valid  out  1          byte valid to uart_tx
//   tx_data_ready  in   1          uart_tx accept
//   grant_id       out  IW         current / last granted requester
//   busy           out  1          grant locked
//   timeout_pulse  out  1          one-cycle pulse on a revoked grant
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    localparam int unsigned IW         = grant_width(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_data_valid,
    input  logic                 tx_data_ready,
    output logic [IW-1:0]        grant_id,
    output logic                 busy,
    output logic                 timeout_pulse
);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    logic          pick_found;
    logic [IW-1:0] pick_idx;

    logic [7:0]    sel_data;
    logic          sel_valid;
    logic          sel_last;
    logic          xfer;
    logic [IW-1:0] next_ptr;
    logic          tmo_hit;

    rr_picker #(
        .N (NUM_REQ),
        .W (IW)
    ) u_rr_picker (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Mux the granted requester's byte stream.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IW'(i)) begin
                sel_data  = req_data[i*8 +: 8];
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
            end
        end
    end

    assign xfer     = (state_q == LOCK) && sel_valid && tx_data_ready;
    assign next_ptr = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);

`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_pulse_q;

    // Counts only cycles where the granted requester has nothing to offer;
    // back-pressure from uart_tx is not a stall. Held at 0 in IDLE so every
    // new grant starts from a cleared count.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_hit   = 1'b0;
        if (state_q == IDLE) begin
            tmo_cnt_d = '0;
        end else if (xfer) begin
            tmo_cnt_d = '0;
        end else if (!sel_valid) begin
            tmo_cnt_d = tmo_cnt_q + 32'd1;
            if (tmo_cnt_d >= 32'(TIMEOUT_CYC)) begin
                tmo_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q   <= '0;
            tmo_pulse_q <= 1'b0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_pulse_q <= tmo_hit;
        end
    end

    assign timeout_pulse = tmo_pulse_q;
`else
    logic unused_tmo;
    assign unused_tmo    = (TIMEOUT_CYC == 0);
    assign tmo_hit       = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        tx_data       = '0;
        tx_data_valid = 1'b0;
        req_ready     = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                tx_data_valid = sel_valid;
                tx_data       = sel_valid ? sel_data : 8'h00;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_q == IW'(i)) begin
                        req_ready[i] = tx_data_ready;
                    end
                end
                if ((xfer && sel_last) || tmo_hit) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == LOCK);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CYC=16). Requesters are
// modelled as small byte FIFOs; every accepted byte on the uart_tx side is logged
// with its grant_id and cycle number and compared against hand-written sequences.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TMO     = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           tx_data;
    logic                 tx_data_valid;
    logic                 tx_data_ready;
    logic [1:0]           grant_id;
    logic                 busy;
    logic                 timeout_pulse;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0]  fifo [NUM_REQ][16];
    int          head [NUM_REQ];
    int          tail [NUM_REQ];

    logic [31:0] log_data [64];
    logic [31:0] log_gid  [64];
    logic [31:0] log_cyc  [64];
    int          log_n = 0;
    int          cyc   = 0;
    int          rcnt  = 0;
    int          ready_mode = 0;  // 0: always ready, 1: every 4th cycle, 2: never
    int          pulse_cnt  = 0;
    int          base;
    int          idle_bad;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic l);
        fifo[i][tail[i] % 16] = {l, d};
        tail[i]++;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NUM_REQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    endtask

    task automatic drive();
        logic [8:0] v;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (head[i] != tail[i]) begin
                v                = fifo[i][head[i] % 16];
                req_valid[i]     = 1'b1;
                req_data[i*8 +: 8] = v[7:0];
                req_last[i]      = v[8];
            end else begin
                req_valid[i]     = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]      = 1'b0;
            end
        end
    endtask

    // One clock: sample handshakes at negedge, advance the requester FIFOs just
    // after the posedge, re-drive, and return with outputs settled.
    task automatic step();
        logic [NUM_REQ-1:0] acc;
        @(negedge clk);
        cyc++;
        acc = req_valid & req_ready;
        if (tx_data_valid && tx_data_ready && log_n < 64) begin
            log_data[log_n] = 32'(tx_data);
            log_gid[log_n]  = 32'(grant_id);
            log_cyc[log_n]  = 32'(cyc);
            log_n++;
        end
        if (timeout_pulse) pulse_cnt++;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) head[i]++;
        end
        rcnt++;
        tx_data_ready = (ready_mode == 0) ? 1'b1 :
                        (ready_mode == 1) ? (rcnt % 4 == 3) : 1'b0;
        drive();
        #1;
    endtask

    task automatic run_until(input string tag, input int n, input int max_cyc);
        for (int k = 0; k < max_cyc && log_n < n; k++) step();
        check_eq(tag, 32'(log_n), 32'(n));
    endtask

    task automatic check_log(input string tag, input int k, input logic [7:0] d,
                             input logic [1:0] g);
        if (k < 64) begin
            check_eq({tag, "_data"}, log_data[k], 32'(d));
            check_eq({tag, "_gid"}, log_gid[k], 32'(g));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(tx_data_valid), 0);
        check_eq({tag, "_data"}, 32'(tx_data), 0);
        check_eq({tag, "_ready"}, 32'(req_ready), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_gid"}, 32'(grant_id), 0);
        check_eq({tag, "_tmo"}, 32'(timeout_pulse), 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        clear_all();
        drive();
        #1;
        check_reset_outputs(tag);
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        rst           = 1'b1;
        req_data      = '0;
        req_valid     = '0;
        req_last      = '0;
        tx_data_ready = 1'b1;
        clear_all();
        #1;
        check_reset_outputs("rst0");

        // Idle after reset release: nothing granted for 100 cycles.
        step();
        rst = 1'b0;
        idle_bad = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (tx_data_valid || busy || grant_id != 2'd0) idle_bad++;
        end
        check_eq("idle_100", 32'(idle_bad), 0);

        // Req0 3-byte packet with ready every 4th cycle.
        ready_mode = 1;
        push(0, 8'h48, 1'b0);
        push(0, 8'h49, 1'b0);
        push(0, 8'h0A, 1'b1);
        drive();
        #1;
        check_eq("pkt1_idle_valid", 32'(tx_data_valid), 0);
        check_eq("pkt1_idle_ready", 32'(req_ready), 0);
        step();
        check_eq("pkt1_busy", 32'(busy), 1);
        check_eq("pkt1_first_valid", 32'(tx_data_valid), 1);
        check_eq("pkt1_first_data", 32'(tx_data), 'h48);
        run_until("pkt1_count", 3, 60);
        check_eq("pkt1_busy_drop", 32'(busy), 0);
        check_log("pkt1_b0", 0, 8'h48, 2'd0);
        check_log("pkt1_b1", 1, 8'h49, 2'd0);
        check_log("pkt1_b2", 2, 8'h0A, 2'd0);
        for (int k = 0; k < 10; k++) step();
        check_eq("pkt1_no_extra", 32'(log_n), 3);

        // rr_ptr is now 1: req0 and req1 together must serve req1 first.
        ready_mode = 0;
        base = log_n;
        push(0, 8'h11, 1'b1);
        push(1, 8'h22, 1'b1);
        drive();
        run_until("rr1_count", base + 2, 20);
        check_log("rr1_first", base, 8'h22, 2'd1);
        check_log("rr1_second", base + 1, 8'h11, 2'd0);
        check_eq("rr1_gap", log_cyc[base + 1] - log_cyc[base], 2);

        // Reset brings rr_ptr back to 0; req0 and req2 together.
        do_reset("rst1");
        base = log_n;
        push(0, 8'hA0, 1'b0);
        push(0, 8'hA1, 1'b0);
        push(0, 8'hA2, 1'b1);
        push(2, 8'hC0, 1'b0);
        push(2, 8'hC1, 1'b1);
        drive();
        run_until("pair_count", base + 5, 40);
        check_log("pair_a0", base, 8'hA0, 2'd0);
        check_log("pair_a1", base + 1, 8'hA1, 2'd0);
        check_log("pair_a2", base + 2, 8'hA2, 2'd0);
        check_log("pair_c0", base + 3, 8'hC0, 2'd2);
        check_log("pair_c1", base + 4, 8'hC1, 2'd2);
        check_eq("pair_back2back", log_cyc[base + 1] - log_cyc[base], 1);
        check_eq("pair_one_idle", log_cyc[base + 3] - log_cyc[base + 2], 2);

        // rr_ptr is 3: req3 first, then wrap to req1 (single-byte packet).
        base = log_n;
        push(1, 8'hB0, 1'b1);
        push(3, 8'hD0, 1'b0);
        push(3, 8'hD1, 1'b1);
        drive();
        run_until("wrap_count", base + 3, 30);
        check_log("wrap_d0", base, 8'hD0, 2'd3);
        check_log("wrap_d1", base + 1, 8'hD1, 2'd3);
        check_log("wrap_b0", base + 2, 8'hB0, 2'd1);

        // Reset on byte 2 of a 5-byte packet, then a fresh request from req1.
        base = log_n;
        push(0, 8'hE0, 1'b0);
        push(0, 8'hE1, 1'b0);
        push(0, 8'hE2, 1'b0);
        push(0, 8'hE3, 1'b0);
        push(0, 8'hE4, 1'b1);
        drive();
        run_until("mid_count", base + 1, 20);
        check_eq("mid_byte2", 32'(tx_data), 'hE1);
        do_reset("rst_mid");
        check_eq("mid_busy_after", 32'(busy), 0);
        base = log_n;
        push(1, 8'hF0, 1'b0);
        push(1, 8'hF1, 1'b1);
        drive();
        run_until("fresh_count", base + 2, 20);
        check_log("fresh_f0", base, 8'hF0, 2'd1);
        check_log("fresh_f1", base + 1, 8'hF1, 2'd1);
        for (int k = 0; k < 5; k++) step();
        check_eq("fresh_no_stale", 32'(log_n), 32'(base + 2));

        // Granted req0 goes silent after its first byte while req2 waits.
        base = log_n;
        pulse_cnt = 0;
        push(0, 8'h60, 1'b0);
        drive();
        run_until("stall_count", base + 1, 20);
        push(2, 8'h62, 1'b1);
        drive();
        #1;
        check_eq("stall_req2_ready", 32'(req_ready[2]), 0);
        check_eq("stall_valid", 32'(tx_data_valid), 0);
`ifdef UART_ARB_TIMEOUT_EN
        for (int k = 0; k < TMO - 1; k++) step();
        check_eq("tmo_pre_pulse", 32'(timeout_pulse), 0);
        check_eq("tmo_pre_busy", 32'(busy), 1);
        step();
        check_eq("tmo_pulse", 32'(timeout_pulse), 1);
        check_eq("tmo_busy_drop", 32'(busy), 0);
        step();
        check_eq("tmo_pulse_end", 32'(timeout_pulse), 0);
        check_eq("tmo_regrant_busy", 32'(busy), 1);
        check_eq("tmo_regrant_gid", 32'(grant_id), 2);
        check_eq("tmo_regrant_data", 32'(tx_data), 'h62);
        run_until("tmo_count", base + 2, 10);
        check_log("tmo_h0", base + 1, 8'h62, 2'd2);
`else
        for (int k = 0; k < 40; k++) step();
        check_eq("hold_tmo", 32'(pulse_cnt), 0);
        check_eq("hold_busy", 32'(busy), 1);
        check_eq("hold_gid", 32'(grant_id), 0);
        check_eq("hold_valid", 32'(tx_data_valid), 0);
        check_eq("hold_req2_ready", 32'(req_ready[2]), 0);
        check_eq("hold_count", 32'(log_n), 32'(base + 1));
        push(0, 8'h61, 1'b1);
        drive();
        run_until("hold_done_count", base + 3, 20);
        check_log("hold_g0", base, 8'h60, 2'd0);
        check_log("hold_g1", base + 1, 8'h61, 2'd0);
        check_log("hold_h0", base + 2, 8'h62, 2'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
